tlc_junction_sched: RTL and testbench



---
 rtl/tlc_junction_sched.sv | 164 ++++++++++++++++
 tb/tb_tlc_junction_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tlc_junction_sched.sv
// tlc_junction_sched: two-road junction controller. It serves road A, road B
// and an optional pedestrian phase in round-robin order, and it rests on green
// while no other requester is waiting.
// Build option: define TLC_PED_EN to enable the pedestrian requester and the
// WALK phase. When TLC_PED_EN is undefined, the controller only alternates
// between roads A and B.
module tlc_junction_sched #(
   parameter int unsigned GREEN_MIN = 4,
   parameter int unsigned GREEN_MAX = 10,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned CLEAR_T   = 1,
   parameter int unsigned WALK_T    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reqA,
   input  logic       reqB,
   input  logic       ped_btn,
   output logic [2:0] outpA,
   output logic [2:0] outpB,
   output logic       walk,
   output logic [1:0] grant
);

   typedef enum logic [1:0] {
      S_GREEN  = 2'b00,
      S_YELLOW = 2'b01,
      S_CLEAR  = 2'b10,
      S_WALK   = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OWN_A = 2'b00,
      OWN_B = 2'b01,
      OWN_P = 2'b10
   } owner_t;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_G = 3'b010;
   localparam logic [2:0] LAMP_Y = 3'b001;

   // The timer counts from 0 on the first cycle of a state, so thresholds are duration-1.
   localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
   localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
   localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
   localparam logic [7:0] CLR_M1  = 8'(CLEAR_T - 1);
   localparam logic [7:0] WLK_M1  = 8'(WALK_T - 1);

   state_t     state, nxt_state;
   owner_t     owner, nxt_owner, pick;
   logic [7:0] timer;
   logic       ped_pend;
   logic       own_req, other_pend;

   function automatic logic [2:0] road_lamp(input state_t st, input owner_t own,
                                            input owner_t road);
      if (own == road && st == S_GREEN)  return LAMP_G;
      if (own == road && st == S_YELLOW) return LAMP_Y;
      return LAMP_R;
   endfunction

   // Classify the pending requesters relative to the current owner.
   always_comb begin
      own_req    = 1'b0;
      other_pend = 1'b0;
      case (owner)
         OWN_A: begin
            own_req    = reqA;
            other_pend = reqB | ped_pend;
         end
         OWN_B: begin
            own_req    = reqB;
            other_pend = reqA | ped_pend;
         end
         default: begin
            own_req    = 1'b0;
            other_pend = reqA | reqB | ped_pend;
         end
      endcase
   end

   // Round-robin choice of the next owner at the end of CLEAR.
   always_comb begin
      pick = OWN_A;
`ifdef TLC_PED_EN
      case (owner)
         OWN_A:   pick = reqB ? OWN_B : (ped_pend ? OWN_P : OWN_A);
         OWN_B:   pick = ped_pend ? OWN_P : (reqA ? OWN_A : OWN_B);
         default: pick = reqA ? OWN_A : (reqB ? OWN_B : (ped_pend ? OWN_P : OWN_A));
      endcase
`else
      case (owner)
         OWN_B:   pick = reqA ? OWN_A : OWN_B;
         default: pick = reqB ? OWN_B : OWN_A;
      endcase
`endif
   end

   // Decide the next phase and owner from the current phase timer and the requests.
   always_comb begin
      nxt_state = state;
      nxt_owner = owner;
      case (state)
         S_GREEN: begin
            if (other_pend && ((timer >= GMIN_M1 && !own_req) || timer >= GMAX_M1))
               nxt_state = S_YELLOW;
         end
         S_YELLOW: begin
            if (timer >= YEL_M1) nxt_state = S_CLEAR;
         end
         S_CLEAR: begin
            if (timer >= CLR_M1) begin
               nxt_owner = pick;
               nxt_state = (pick == OWN_P) ? S_WALK : S_GREEN;
            end
         end
         S_WALK: begin
            if (timer >= WLK_M1) nxt_state = S_CLEAR;
         end
         default: nxt_state = S_GREEN;
      endcase
   end

`ifdef TLC_PED_EN
   // Hold a pedestrian press until WALK is entered; entering WALK also absorbs a press in that same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         ped_pend <= 1'b0;
      else if (nxt_state == S_WALK && state != S_WALK)
         ped_pend <= 1'b0;
      else if (ped_btn)
         ped_pend <= 1'b1;
   end
`else
   logic unused_ped;
   assign ped_pend   = 1'b0;
   assign unused_ped = ped_btn;
`endif

   // Phase register, saturating phase timer, and lamp/grant outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_GREEN;
         owner <= OWN_A;
         timer <= '0;
         outpA <= LAMP_G;
         outpB <= LAMP_R;
         walk  <= 1'b0;
         grant <= 2'b00;
      end else begin
         state <= nxt_state;
         owner <= nxt_owner;
         if (nxt_state != state)
            timer <= '0;
         else if (timer != 8'hFF)
            timer <= timer + 8'd1;
         outpA <= road_lamp(nxt_state, nxt_owner, OWN_A);
         outpB <= road_lamp(nxt_state, nxt_owner, OWN_B);
         walk  <= (nxt_state == S_WALK);
         grant <= nxt_owner;
      end
   end

endmodule

// File: tb/tb_tlc_junction_sched.sv
// Scoreboard bench for tlc_junction_sched with default parameters. The
// stimulus process pushes the hand-derived lamp/grant state expected after
// each clock edge. The monitor then pops each entry and compares it one time
// unit after that edge. Sections guarded by TLC_PED_EN run in the build that
// has the pedestrian feature.
module tb_tlc_junction_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       reqA = 1'b0;
   logic       reqB = 1'b0;
   logic       ped_btn = 1'b0;
   logic [2:0] outpA, outpB;
   logic       walk;
   logic [1:0] grant;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] Y = 3'b001;
   localparam logic [1:0] GA = 2'b00;
   localparam logic [1:0] GB = 2'b01;
   localparam logic [1:0] GP = 2'b10;

   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic       w;
      logic [1:0] g;
   } exp_t;

   typedef struct {
      exp_t  e;
      string name;
      int    idx;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    failures = 0;

   tlc_junction_sched #(
      .GREEN_MIN(4),
      .GREEN_MAX(10),
      .YELLOW_T (2),
      .CLEAR_T  (1),
      .WALK_T   (3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .reqA   (reqA),
      .reqB   (reqB),
      .ped_btn(ped_btn),
      .outpA  (outpA),
      .outpB  (outpB),
      .walk   (walk),
      .grant  (grant)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic step(input string name, input int idx, input logic r, input logic a,
                       input logic b, input logic p, input logic [2:0] ea,
                       input logic [2:0] eb, input logic ew, input logic [1:0] eg);
      item_t it;
      @(negedge clk);
      rst     = r;
      reqA    = a;
      reqB    = b;
      ped_btn = p;
      it.e    = '{a: ea, b: eb, w: ew, g: eg};
      it.name = name;
      it.idx  = idx;
      sb.push_back(it);
   endtask

   // Monitor: pop one expectation per edge and check it, together with the lamp safety rules.
   always begin
      item_t it;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         it = sb.pop_front();
         checks++;
         if ({outpA, outpB, walk, grant} !== it.e) begin
            failures++;
            $display("FAIL %s[%0d] got A=%b B=%b walk=%b grant=%b expected A=%b B=%b walk=%b grant=%b",
                     it.name, it.idx, outpA, outpB, walk, grant, it.e.a, it.e.b, it.e.w, it.e.g);
         end
         checks++;
         if ((outpA != R && outpB != R) || (walk && (outpA != R || outpB != R))) begin
            failures++;
            $display("FAIL safety[%s %0d] got A=%b B=%b walk=%b", it.name, it.idx, outpA, outpB, walk);
         end
      end
   end

   initial begin
      // Scenario 1: a lone request on A keeps A green.
      step("s1", 0, 1, 1, 0, 0, G, R, 0, GA);
      for (int i = 1; i <= 50; i++) step("s1", i, 0, 1, 0, 0, G, R, 0, GA);

      // Scenario 2: only B requests; A yields after the minimum green period.
      step("s2", 0, 1, 0, 1, 0, G, R, 0, GA);
      for (int i = 1; i <= 3; i++) step("s2", i, 0, 0, 1, 0, G, R, 0, GA);
      step("s2", 4, 0, 0, 1, 0, Y, R, 0, GA);
      step("s2", 5, 0, 0, 1, 0, Y, R, 0, GA);
      step("s2", 6, 0, 0, 1, 0, R, R, 0, GA);
      for (int i = 7; i <= 10; i++) step("s2", i, 0, 0, 1, 0, R, G, 0, GB);

      // Scenario 3: both roads contested, so each green runs to the maximum.
      step("s3", 0, 1, 1, 1, 0, G, R, 0, GA);
      for (int i = 1; i <= 9; i++) step("s3", i, 0, 1, 1, 0, G, R, 0, GA);
      step("s3", 10, 0, 1, 1, 0, Y, R, 0, GA);
      step("s3", 11, 0, 1, 1, 0, Y, R, 0, GA);
      step("s3", 12, 0, 1, 1, 0, R, R, 0, GA);
      for (int i = 13; i <= 22; i++) step("s3", i, 0, 1, 1, 0, R, G, 0, GB);
      step("s3", 23, 0, 1, 1, 0, R, Y, 0, GB);
      step("s3", 24, 0, 1, 1, 0, R, Y, 0, GB);
      step("s3", 25, 0, 1, 1, 0, R, R, 0, GB);
      step("s3", 26, 0, 1, 1, 0, G, R, 0, GA);
      step("s3", 27, 0, 1, 1, 0, G, R, 0, GA);

      // The owner drops its request after the minimum, so the owner yields on the next edge.
      step("drop", 0, 1, 1, 1, 0, G, R, 0, GA);
      for (int i = 1; i <= 5; i++) step("drop", i, 0, 1, 1, 0, G, R, 0, GA);
      step("drop", 6, 0, 0, 1, 0, Y, R, 0, GA);
      step("drop", 7, 0, 0, 1, 0, Y, R, 0, GA);
      step("drop", 8, 0, 0, 1, 0, R, R, 0, GA);
      step("drop", 9, 0, 0, 1, 0, R, G, 0, GB);

      // Scenario 5: reset during yellow, with a pedestrian press taken earlier.
      step("s5", 0, 1, 0, 1, 0, G, R, 0, GA);
      step("s5", 1, 0, 0, 1, 1, G, R, 0, GA);
      step("s5", 2, 0, 0, 1, 0, G, R, 0, GA);
      step("s5", 3, 0, 0, 1, 0, G, R, 0, GA);
      step("s5", 4, 0, 0, 1, 0, Y, R, 0, GA);
      step("s5", 5, 1, 0, 0, 0, G, R, 0, GA);
      for (int i = 6; i <= 13; i++) step("s5", i, 0, 0, 0, 0, G, R, 0, GA);

`ifdef TLC_PED_EN
      // Scenario 4: B is served first, then the walk phase, then A.
      step("s4", 0, 1, 0, 1, 0, G, R, 0, GA);
      step("s4", 1, 0, 0, 1, 1, G, R, 0, GA);
      step("s4", 2, 0, 0, 1, 0, G, R, 0, GA);
      step("s4", 3, 0, 0, 1, 0, G, R, 0, GA);
      step("s4", 4, 0, 0, 1, 0, Y, R, 0, GA);
      step("s4", 5, 0, 0, 1, 0, Y, R, 0, GA);
      step("s4", 6, 0, 0, 1, 0, R, R, 0, GA);
      step("s4", 7, 0, 0, 1, 0, R, G, 0, GB);
      for (int i = 8; i <= 10; i++) step("s4", i, 0, 0, 0, 0, R, G, 0, GB);
      step("s4", 11, 0, 0, 0, 0, R, Y, 0, GB);
      step("s4", 12, 0, 0, 0, 0, R, Y, 0, GB);
      step("s4", 13, 0, 0, 0, 0, R, R, 0, GB);
      for (int i = 14; i <= 16; i++) step("s4", i, 0, 0, 0, 0, R, R, 1, GP);
      step("s4", 17, 0, 0, 0, 0, R, R, 0, GP);
      step("s4", 18, 0, 0, 0, 0, G, R, 0, GA);
      step("s4", 19, 0, 0, 0, 0, G, R, 0, GA);
`else
      // Scenario 6: pedestrian presses have no effect in this build.
      step("s6", 0, 1, 1, 0, 0, G, R, 0, GA);
      for (int i = 1; i <= 20; i++) step("s6", i, 0, 1, 0, i[0], G, R, 0, GA);
`endif

      @(posedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog: the stimulus above is finite, so this limit is only a backstop.
   initial begin
      #100000;
      $display("FAIL watchdog got timeout, expected finish");
      $fatal(1, "timeout");
   end

endmodule
